ram_boot_loader: RTL and testbench

- Serial boot-loader stage sitting directly upstream of the 4 KiB x 8 program/data RAM.
- Consumes a byte stream from the UART receiver, parses a framed load command and writes the payload into the RAM through its write port (addr/data_in/we).
- Holds the CPU in reset until a frame is received and its checksum verifies.
- Lets a new program be loaded over serial without rebuilding the RAM init image.

---
 rtl/ram_boot_loader_if.sv | 27 ++
 rtl/ram_boot_loader.sv | 174 +++++++++++++++++
 tb/tb_ram_boot_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_boot_loader_if.sv
// ram_boot_loader_if: byte-stream input and RAM write / status outputs of the
// serial boot loader.
//   rx_data[7:0], rx_valid : received byte and its one-cycle strobe
//   mem_addr[11:0], mem_data[7:0], mem_we : RAM write port
//   cpu_hold, load_done, load_error, busy : loader status
// master = byte source / observer side, slave = the loader itself.
interface ram_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic        busy;

    modport master (
        output rx_data, rx_valid,
        input  mem_addr, mem_data, mem_we, cpu_hold, load_done, load_error, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output mem_addr, mem_data, mem_we, cpu_hold, load_done, load_error, busy
    );
endinterface

// File: rtl/ram_boot_loader.sv
// ram_boot_loader: parses framed load commands from a UART byte stream and
// writes the payload into the 4 KiB program RAM, holding the CPU in reset
// until a frame with a valid checksum has been loaded.
// Frame: SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, payload[LEN], CHK
// where CHK = ~(8-bit sum of payload bytes).
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : slave modport of ram_boot_loader_if (byte stream in, RAM write
//           port and status out)
module ram_boot_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input logic              clk,
    input logic              reset,
    ram_boot_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_CHK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nx;
    logic [11:0]       addr_cnt;
    logic [11:0]       remain;
    logic [7:0]        sum;
    logic [CNT_W-1:0]  idle_cnt;

    logic timeout;
    logic start;
    logic hdr_err;
    logic chk_good;
    logic chk_bad;
    logic wr;

    // A byte arriving on the last idle cycle wins over the timeout.
    assign timeout = (state != S_IDLE) && !bus.rx_valid && (idle_cnt == CNT_LAST);

    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        hdr_err  = 1'b0;
        chk_good = 1'b0;
        chk_bad  = 1'b0;
        wr       = 1'b0;
        if (timeout) begin
            state_nx = S_IDLE;
        end else if (bus.rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        start    = 1'b1;
                        state_nx = S_ADDR_H;
                    end
                end
                S_ADDR_H: begin
                    if (bus.rx_data[7:4] != 4'h0) begin
                        hdr_err  = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_ADDR_L;
                    end
                end
                S_ADDR_L: state_nx = S_LEN_H;
                S_LEN_H: begin
                    if (bus.rx_data[7:4] != 4'h0) begin
                        hdr_err  = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    state_nx = ({remain[11:8], bus.rx_data} != 12'd0) ? S_DATA : S_CHK;
                end
                S_DATA: begin
                    wr = 1'b1;
                    if (remain == 12'd1) begin
                        state_nx = S_CHK;
                    end
                end
                S_CHK: begin
                    if (bus.rx_data == ~sum) begin
                        chk_good = 1'b1;
                    end else begin
                        chk_bad = 1'b1;
                    end
                    state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Datapath: header fields, payload write port, checksum and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt       <= '0;
            remain         <= '0;
            sum            <= '0;
            idle_cnt       <= '0;
            bus.mem_addr   <= '0;
            bus.mem_data   <= '0;
            bus.mem_we     <= 1'b0;
            bus.cpu_hold   <= 1'b1;
            bus.load_done  <= 1'b0;
            bus.load_error <= 1'b0;
        end else begin
            bus.mem_we <= wr;

            if (state == S_IDLE || bus.rx_valid || timeout) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CNT_ONE;
            end

            if (bus.rx_valid && !timeout) begin
                case (state)
                    S_ADDR_H: addr_cnt[11:8] <= bus.rx_data[3:0];
                    S_ADDR_L: addr_cnt[7:0]  <= bus.rx_data;
                    S_LEN_H:  remain[11:8]   <= bus.rx_data[3:0];
                    S_LEN_L:  remain[7:0]    <= bus.rx_data;
                    default: ;
                endcase
            end

            if (wr) begin
                bus.mem_addr <= addr_cnt;
                bus.mem_data <= bus.rx_data;
                addr_cnt     <= addr_cnt + 12'd1;
                remain       <= remain - 12'd1;
                sum          <= sum + bus.rx_data;
            end

            if (start) begin
                sum            <= '0;
                bus.cpu_hold   <= 1'b1;
                bus.load_done  <= 1'b0;
                bus.load_error <= 1'b0;
            end

            if (hdr_err || chk_bad || timeout) begin
                bus.load_error <= 1'b1;
                bus.cpu_hold   <= 1'b1;
            end

            if (chk_good) begin
                bus.load_done <= 1'b1;
                bus.cpu_hold  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_boot_loader.sv
// tb_ram_boot_loader: drives byte frames into ram_boot_loader and compares
// RAM writes and status flags against a frame-level reference model.
module tb_ram_boot_loader;

    localparam int unsigned TMO  = 50;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic clk = 1'b0;
    logic reset;

    ram_boot_loader_if bus ();

    ram_boot_loader #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frame[$];
    logic [19:0] exp_w[$];
    logic        exp_done;
    logic        exp_err;

    // Observed writes ({addr,data}) and lengths of consecutive mem_we runs.
    logic [19:0] obs_w[$];
    int          runs[$];
    int          we_run = 0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            obs_w.push_back({bus.mem_addr, bus.mem_data});
            we_run++;
        end else if (we_run > 0) begin
            runs.push_back(we_run);
            we_run = 0;
        end
    end

    // Reference model: interpret the frame bytes directly.
    task automatic model_frame();
        int          p;
        logic [11:0] a;
        int          n;
        logic [7:0]  s;
        exp_w.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        p = 0;
        while (p < frame.size() && frame[p] != SYNC) p++;
        if (frame[p+1][7:4] != 4'h0) begin exp_err = 1'b1; return; end
        if (frame[p+3][7:4] != 4'h0) begin exp_err = 1'b1; return; end
        a = {frame[p+1][3:0], frame[p+2]};
        n = int'({frame[p+3][3:0], frame[p+4]});
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({a + 12'(i), frame[p+5+i]});
            s = s + frame[p+5+i];
        end
        if (frame[p+5+n] == ~s) exp_done = 1'b1;
        else                    exp_err  = 1'b1;
    endtask

    task automatic build_random_frame(input int max_len, input bit good);
        logic [11:0] a;
        logic [11:0] n;
        logic [7:0]  s;
        logic [7:0]  b;
        a = 12'($urandom);
        n = 12'($urandom_range(max_len, 1));
        frame.delete();
        frame.push_back(SYNC);
        frame.push_back({4'h0, a[11:8]});
        frame.push_back(a[7:0]);
        frame.push_back({4'h0, n[11:8]});
        frame.push_back(n[7:0]);
        s = 8'h00;
        for (int i = 0; i < int'(n); i++) begin
            b = 8'($urandom);
            frame.push_back(b);
            s = s + b;
        end
        if (good) frame.push_back(~s);
        else      frame.push_back(~s ^ 8'($urandom_range(255, 1)));
    endtask

    // gap = idle cycles between bytes (0 = back-to-back strobes).
    task automatic send_frame(input int gap);
        for (int i = 0; i < frame.size(); i++) begin
            @(negedge clk);
            bus.rx_data  = frame[i];
            bus.rx_valid = 1'b1;
            if (gap > 0) begin
                @(negedge clk);
                bus.rx_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_addr !== 12'h000) begin errors++; $display("FAIL reset mem_addr: got %h expected 000", bus.mem_addr); end
        checks++; if (bus.mem_data !== 8'h00) begin errors++; $display("FAIL reset mem_data: got %h expected 00", bus.mem_data); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL reset cpu_hold: got %b expected 1", bus.cpu_hold); end
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL reset load_done: got %b expected 0", bus.load_done); end
        checks++; if (bus.load_error !== 1'b0) begin errors++; $display("FAIL reset load_error: got %b expected 0", bus.load_error); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset idle: got hold=%b busy=%b expected hold=1 busy=0", bus.cpu_hold, bus.busy); end
    endtask

    task automatic test_directed_frames();
        string name;
        int    gap;
        int    base;
        int    rbase;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: begin name = "good";     gap = 1; frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h99}; end
                1: begin name = "wrap";     gap = 2; frame = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'h55, 8'h00}; end
                2: begin name = "bad_chk";  gap = 1; frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h00}; end
                3: begin name = "hdr_addr"; gap = 1; frame = '{8'hA5, 8'h10}; end
                4: begin name = "hdr_len";  gap = 1; frame = '{8'hA5, 8'h00, 8'h00, 8'h20}; end
                5: begin name = "zero_len"; gap = 1; frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}; end
                default: begin name = "good_b2b"; gap = 0; frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h99}; end
            endcase
            model_frame();
            base  = obs_w.size();
            rbase = runs.size();
            send_frame(gap);
            checks++; if (obs_w.size() - base !== exp_w.size()) begin errors++; $display("FAIL %s write_count: got %0d expected %0d", name, obs_w.size() - base, exp_w.size()); end
            for (int i = 0; i < exp_w.size(); i++) begin
                if (base + i < obs_w.size()) begin
                    checks++; if (obs_w[base+i] !== exp_w[i]) begin errors++; $display("FAIL %s write%0d addr_data: got %h expected %h", name, i, obs_w[base+i], exp_w[i]); end
                end
            end
            if (gap == 0 && exp_w.size() > 0) begin
                checks++; if (runs.size() != rbase + 1 || runs[rbase] != exp_w.size()) begin errors++; $display("FAIL %s we_run: got %0d runs expected one run of %0d", name, runs.size() - rbase, exp_w.size()); end
            end
            checks++; if (bus.load_done !== exp_done) begin errors++; $display("FAIL %s load_done: got %b expected %b", name, bus.load_done, exp_done); end
            checks++; if (bus.load_error !== exp_err) begin errors++; $display("FAIL %s load_error: got %b expected %b", name, bus.load_error, exp_err); end
            checks++; if (bus.cpu_hold !== !exp_done) begin errors++; $display("FAIL %s cpu_hold: got %b expected %b", name, bus.cpu_hold, !exp_done); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", name, bus.busy); end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int rbase;
        for (int k = 0; k < 5; k++) begin
            build_random_frame(24, 1'b1);
            model_frame();
            base  = obs_w.size();
            rbase = runs.size();
            send_frame(0);
            checks++; if (obs_w.size() - base !== exp_w.size()) begin errors++; $display("FAIL b2b%0d write_count: got %0d expected %0d", k, obs_w.size() - base, exp_w.size()); end
            for (int i = 0; i < exp_w.size(); i++) begin
                if (base + i < obs_w.size()) begin
                    checks++; if (obs_w[base+i] !== exp_w[i]) begin errors++; $display("FAIL b2b%0d write%0d addr_data: got %h expected %h", k, i, obs_w[base+i], exp_w[i]); end
                end
            end
            checks++; if (runs.size() != rbase + 1 || runs[rbase] != exp_w.size()) begin errors++; $display("FAIL b2b%0d we_run: got %0d runs expected one run of %0d", k, runs.size() - rbase, exp_w.size()); end
            checks++; if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL b2b%0d status: got done=%b hold=%b expected done=1 hold=0", k, bus.load_done, bus.cpu_hold); end
        end
    endtask

    task automatic test_random_frames();
        int base;
        for (int k = 0; k < 20; k++) begin
            build_random_frame(16, $urandom_range(1, 0) == 1);
            model_frame();
            base = obs_w.size();
            send_frame($urandom_range(3, 1));
            checks++; if (obs_w.size() - base !== exp_w.size()) begin errors++; $display("FAIL rand%0d write_count: got %0d expected %0d", k, obs_w.size() - base, exp_w.size()); end
            for (int i = 0; i < exp_w.size(); i++) begin
                if (base + i < obs_w.size()) begin
                    checks++; if (obs_w[base+i] !== exp_w[i]) begin errors++; $display("FAIL rand%0d write%0d addr_data: got %h expected %h", k, i, obs_w[base+i], exp_w[i]); end
                end
            end
            checks++; if (bus.load_done !== exp_done || bus.load_error !== exp_err || bus.cpu_hold !== !exp_done) begin
                errors++; $display("FAIL rand%0d status: got done=%b err=%b hold=%b expected done=%b err=%b hold=%b",
                                   k, bus.load_done, bus.load_error, bus.cpu_hold, exp_done, exp_err, !exp_done);
            end
        end
    endtask

    task automatic test_timeout();
        int base;
        int waited;
        base  = obs_w.size();
        frame = '{8'hA5, 8'h00, 8'h00};
        send_frame(1);
        repeat (35) @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.load_error !== 1'b0) begin errors++; $display("FAIL timeout early: got busy=%b err=%b expected busy=1 err=0", bus.busy, bus.load_error); end
        waited = 0;
        while (bus.busy === 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout abort: got busy=%b expected 0 within bound", bus.busy); end
        checks++; if (bus.load_error !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
            errors++; $display("FAIL timeout status: got err=%b hold=%b done=%b expected err=1 hold=1 done=0", bus.load_error, bus.cpu_hold, bus.load_done);
        end
        checks++; if (obs_w.size() !== base) begin errors++; $display("FAIL timeout writes: got %0d expected 0", obs_w.size() - base); end
    endtask

    task automatic test_resync();
        frame = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h01, 8'hFE};
        send_frame(1);
        checks++; if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL resync first_frame: got done=%b hold=%b expected done=1 hold=0", bus.load_done, bus.cpu_hold); end
        @(negedge clk);
        bus.rx_data  = SYNC;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0 || bus.load_error !== 1'b0) begin
            errors++; $display("FAIL resync reenter: got busy=%b hold=%b done=%b err=%b expected 1 1 0 0", bus.busy, bus.cpu_hold, bus.load_done, bus.load_error);
        end
        frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        send_frame(1);
        checks++; if (bus.load_done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL resync finish: got done=%b busy=%b expected done=1 busy=0", bus.load_done, bus.busy); end
    endtask

    task automatic test_reset_mid_data();
        int base;
        frame = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h05};
        send_frame(1);
        base = obs_w.size();
        @(negedge clk);
        bus.rx_data  = 8'h3C;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h040) begin errors++; $display("FAIL midreset pre_we: got we=%b addr=%h expected we=1 addr=040", bus.mem_we, bus.mem_addr); end
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL midreset mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL midreset cpu_hold: got %b expected 1", bus.cpu_hold); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        reset        = 1'b0;
        frame = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(1);
        checks++; if (obs_w.size() !== base) begin errors++; $display("FAIL midreset discarded_writes: got %0d expected 0", obs_w.size() - base); end
        checks++; if (bus.busy !== 1'b0 || bus.load_done !== 1'b0 || bus.load_error !== 1'b0) begin
            errors++; $display("FAIL midreset discarded_status: got busy=%b done=%b err=%b expected 0 0 0", bus.busy, bus.load_done, bus.load_error);
        end
    endtask

    initial begin
        test_reset();
        test_directed_frames();
        test_back_to_back();
        test_random_frames();
        test_timeout();
        test_resync();
        test_reset_mid_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
